mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mips_pkg.sv | 13 +
 rtl/mult_unit.sv | 100 ++++++++++
 tb/tb_mult_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: multiplier FSM state type and iteration constants.
package mips_pkg;

   localparam int MULT_CYCLES = 32;
   localparam int MULT_CNT_W  = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } multState_t;

endpackage

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for mult/multu with sign/magnitude handling.
// The product lands in hi/lo on entry to DONE; a flush or reset abandons the operation silently.
module mult_unit #(
   parameter int MULT_CYCLES = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   sgn,
   input  logic [MULT_CYCLES-1:0] srca,
   input  logic [MULT_CYCLES-1:0] srcb,
   input  logic                   flush,
   output logic                   busy,
   output logic                   done,
   output logic [MULT_CYCLES-1:0] hi,
   output logic [MULT_CYCLES-1:0] lo
);
   import mips_pkg::*;

   localparam int W = MULT_CYCLES;

   multState_t            state, stateNext;
   logic [MULT_CNT_W-1:0] cnt;
   logic [2*W-1:0]        acc;
   logic [2*W-1:0]        mcandSh;
   logic [W-1:0]          mplier;
   logic                  negRes;

   logic [W-1:0]          magA, magB;
   logic [2*W-1:0]        partial, accSum, prodFinal;
   logic                  lastIter, accept;

   // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
   assign magA      = (sgn && srca[W-1]) ? (~srca + W'(1)) : srca;
   assign magB      = (sgn && srcb[W-1]) ? (~srcb + W'(1)) : srcb;
   assign partial   = mplier[0] ? mcandSh : '0;
   assign accSum    = acc + partial;
   assign prodFinal = negRes ? (~accSum + (2*W)'(1)) : accSum;
   assign lastIter  = (cnt == MULT_CNT_W'(MULT_CYCLES - 1));
   assign accept    = start && !flush;

   assign busy = (state != IDLE);
   assign done = (state == DONE) && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = RUN;
         RUN: begin
            if (flush)         stateNext = IDLE;
            else if (lastIter) stateNext = DONE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         acc     <= '0;
         mcandSh <= '0;
         mplier  <= '0;
         negRes  <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcandSh <= {{W{1'b0}}, magA};
                  mplier  <= magB;
                  negRes  <= sgn && (srca[W-1] ^ srcb[W-1]);
                  acc     <= '0;
                  cnt     <= '0;
               end
            end
            RUN: begin
               if (!flush) begin
                  acc     <= accSum;
                  mcandSh <= mcandSh << 1;
                  mplier  <= mplier >> 1;
                  cnt     <= cnt + MULT_CNT_W'(1);
                  if (lastIter) begin
                     hi <= prodFinal[2*W-1:W];
                     lo <= prodFinal[W-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_unit.sv
// Directed and randomized checks of mult_unit against a plain-arithmetic product model.
module tb_mult_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sgn;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int passCnt  = 0;
   int totalCnt = 0;

   mult_unit #(.MULT_CYCLES(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sgn   (sgn),
      .srca  (srca),
      .srcb  (srcb),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] refProd(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Launch one operation and follow it to its done pulse, checking latency, busy span and product.
   task automatic runOp(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [63:0] expP;
      int doneCyc;
      int busyCyc;
      expP = refProd(s, a, b);
      @(negedge clk);
      start = 1'b1; sgn = s; srca = a; srcb = b;
      @(negedge clk);
      start = 1'b0; sgn = ~s; srca = $urandom; srcb = $urandom;
      doneCyc = 0;
      busyCyc = 0;
      for (int c = 1; c <= 100 && doneCyc == 0; c++) begin
         if (c > 1) @(negedge clk);
         if (busy) busyCyc++;
         if (done) doneCyc = c;
      end
      check({tag, "_lat"}, 64'(doneCyc), 64'd33);
      check({tag, "_busy"}, 64'(busyCyc), 64'd33);
      check({tag, "_prod"}, {hi, lo}, expP);
      @(negedge clk);
      check({tag, "_idle"}, {62'b0, busy, done}, 64'd0);
   endtask

   task automatic watchNoDone(input int n, input string tag);
      int seen;
      seen = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          doneSeen;

      rst = 1'b1; start = 1'b0; sgn = 1'b0; srca = '0; srcb = '0; flush = 1'b0;
      #1;
      check("reset_state", {busy, done, hi, lo}, 66'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      runOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "u_ffxff");
      check("u_ffxff_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      runOp(1'b1, 32'hFFFF_FFFD, 32'd7, "s_m3x7");
      check("s_m3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      runOp(1'b1, 32'h8000_0000, 32'h8000_0000, "s_minxmin");
      check("s_minxmin_const", {hi, lo}, 64'h4000_0000_0000_0000);
      runOp(1'b1, 32'h8000_0000, 32'd1, "s_minx1");
      check("s_minx1_const", {hi, lo}, 64'hFFFF_FFFF_8000_0000);
      runOp(1'b0, 32'h8000_0000, 32'd1, "u_minx1");
      runOp(1'b1, 32'd0, 32'hFFFF_FFFF, "s_0xm1");

      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         runOp(rs, ra, rb, $sformatf("rand%0d", i));
      end

      // Busy/flush scenario.
      runOp(1'b0, 32'd5, 32'd6, "u_5x6");
      check("u_5x6_lo", {32'b0, lo}, 64'd30);
      @(negedge clk);
      start = 1'b1; sgn = 1'b0; srca = 32'd9; srcb = 32'd9;
      @(negedge clk);
      start = 1'b0;
      doneSeen = 0;
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) @(negedge clk);
         if (done) doneSeen++;
         start = (c == 4);
         if (c == 10) flush = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("flush_busy", {62'b0, busy, done}, 64'd0);
      check("flush_nodone", 64'(doneSeen), 64'd0);
      check("flush_hilo", {hi, lo}, 64'd30);
      watchNoDone(40, "flush_noqueue");
      check("flush_hilo_late", {hi, lo}, 64'd30);

      // Asynchronous reset during RUN.
      @(negedge clk);
      start = 1'b1; sgn = 1'b1; srca = 32'h1234_5678; srcb = 32'hF00D_CAFE;
      @(negedge clk);
      start = 1'b0;
      for (int c = 2; c <= 20; c++) @(negedge clk);
      check("rst_pre_busy", {63'b0, busy}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_async", {busy, done, hi, lo}, 66'd0);
      @(negedge clk);
      rst = 1'b0;
      watchNoDone(40, "rst_nodone");
      runOp(1'b0, 32'd2, 32'd3, "post_rst_2x3");
      check("post_rst_lo", {32'b0, lo}, 64'd6);

      // start and flush together in IDLE.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; sgn = 1'b0; srca = 32'd7; srcb = 32'd7;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("prio_busy", {63'b0, busy}, 64'd0);
      check("prio_hilo", {hi, lo}, 64'd6);
      watchNoDone(40, "prio_nostart");
      check("prio_hilo_late", {hi, lo}, 64'd6);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
